// File: rtl/alu_issue_ctrl_pkg.sv
// Shared defaults and ALU operation codes for the ALU issue controller.
// Imported by the command FIFO and the issue controller top.
package alu_issue_ctrl_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int CTRL_W_DEF = 3;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; the head entry is shown combinationally,
// and an empty FIFO presents all-zero data.
module alu_cmd_fifo
   import alu_issue_ctrl_pkg::*;
#(
   parameter int W     = CTRL_W_DEF + 2 * WIDTH_DEF,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands, drives the FIFO head to the ALU and registers
// each result with its flags into a valid/ready response slot.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CTRL_W-1:0] req_ctrl,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_c,
   input  logic              alu_o,
   input  logic              alu_z,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_c,
   output logic              rsp_o,
   output logic              rsp_z,
   output logic              busy
);

   localparam int CW = CTRL_W + 2 * WIDTH;

   logic          push, pop, full, empty;
   logic [CW-1:0] head;

   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [2:0]       rsp_flags_q, rsp_flags_d;

   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = !empty && (!rsp_valid_q || rsp_ready);

   assign {alu_ctrl, alu_a, alu_b} = head;

   alu_cmd_fifo #(
      .W     (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({req_ctrl, req_a, req_b}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // A stalled response holds its payload; a pop refills the slot.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      if (pop) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = alu_result;
         rsp_flags_d  = {alu_c, alu_o, alu_z};
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign {rsp_c, rsp_o, rsp_z} = rsp_flags_q;
   assign busy = !empty || rsp_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives alu_* and a
// queue-based reference model tracks every output cycle by cycle.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int WIDTH  = 32;
   localparam int CTRL_W = 3;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid, req_ready;
   logic [CTRL_W-1:0] req_ctrl;
   logic [WIDTH-1:0]  req_a, req_b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
   logic              alu_c, alu_o, alu_z;
   logic              rsp_valid, rsp_ready;
   logic [WIDTH-1:0]  rsp_result;
   logic              rsp_c, rsp_o, rsp_z;
   logic              busy;

   always #5 clk = ~clk;

   alu_issue_ctrl #(
      .WIDTH  (WIDTH),
      .CTRL_W (CTRL_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ctrl   (req_ctrl),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_c      (alu_c),
      .alu_o      (alu_o),
      .alu_z      (alu_z),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_c      (rsp_c),
      .rsp_o      (rsp_o),
      .rsp_z      (rsp_z),
      .busy       (busy)
   );

   // Returns {c, o, z, result}
   function automatic logic [34:0] alu_ref(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic c, o;
      s = '0; r = '0; c = 1'b0; o = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = {31'd0, $signed(a) < $signed(b)};
         3'd6: r = a << b[4:0];
         default: r = a >> b[4:0];
      endcase
      return {c, o, (r == 32'd0), r};
   endfunction

   logic [34:0] alu_out;
   assign alu_out = alu_ref(alu_ctrl, alu_a, alu_b);
   assign {alu_c, alu_o, alu_z, alu_result} = alu_out;

   int n_chk  = 0;
   int n_pass = 0;

   logic [66:0] m_q[$];
   logic        m_rv;
   logic [31:0] m_res;
   logic [2:0]  m_fl;

   task automatic chk(input string tag, input logic [66:0] obs,
                      input logic [66:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all();
      logic [66:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 67'd0;
      chk("req_ready", 67'(req_ready), 67'(m_q.size() < DEPTH));
      chk("rsp_valid", 67'(rsp_valid), 67'(m_rv));
      chk("busy", 67'(busy), 67'((m_q.size() > 0) || m_rv));
      chk("rsp_result", 67'(rsp_result), 67'(m_res));
      chk("rsp_flags", 67'({rsp_c, rsp_o, rsp_z}), 67'(m_fl));
      chk("alu_head", {alu_ctrl, alu_a, alu_b}, head);
   endtask

   task automatic tick();
      logic push, pop;
      logic [66:0] cmd;
      logic [34:0] r;
      push = req_valid && (m_q.size() < DEPTH);
      pop  = (m_q.size() > 0) && (!m_rv || rsp_ready);
      @(posedge clk);
      if (pop) begin
         cmd   = m_q.pop_front();
         r     = alu_ref(cmd[66:64], cmd[63:32], cmd[31:0]);
         m_rv  = 1'b1;
         m_res = r[31:0];
         m_fl  = r[34:32];
      end else if (rsp_ready) begin
         m_rv = 1'b0;
      end
      if (push) m_q.push_back({req_ctrl, req_a, req_b});
      #1;
      check_all();
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1; req_ctrl = op; req_a = a; req_b = b;
      for (int i = 0; i < 50; i++) begin
         acc = req_ready;
         tick();
         if (acc) break;
      end
      chk("send_accept", 67'(acc), 67'(1));
      req_valid = 1'b0;
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 67'(rsp_valid), 67'(0));
      chk("rst_busy", 67'(busy), 67'(0));
      chk("rst_ready", 67'(req_ready), 67'(1));
      chk("rst_result", 67'({rsp_result, rsp_c, rsp_o, rsp_z}), 67'(0));
      chk("rst_alu", {alu_ctrl, alu_a, alu_b}, 67'(0));
      m_q.delete();
      m_rv = 1'b0; m_res = '0; m_fl = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      logic acc;
      req_valid = 1'b0; req_ctrl = '0; req_a = '0; req_b = '0;
      rsp_ready = 1'b1;
      m_rv = 1'b0; m_res = '0; m_fl = '0;
      #1;
      do_reset();

      // single ADD
      send(ALU_ADD, 32'd5, 32'd7);
      chk("add_lat0", 67'(rsp_valid), 67'(0));
      tick();
      chk("add_valid", 67'(rsp_valid), 67'(1));
      chk("add_res", 67'(rsp_result), 67'(12));
      chk("add_flags", 67'({rsp_c, rsp_o, rsp_z}), 67'(0));
      tick();
      chk("add_idle", 67'(busy), 67'(0));

      // back-to-back SUB
      send(ALU_SUB, 32'd9, 32'd9);
      send(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      chk("sub0_res", 67'(rsp_result), 67'(0));
      chk("sub0_z", 67'(rsp_z), 67'(1));
      tick();
      chk("sub1_valid", 67'(rsp_valid), 67'(1));
      chk("sub1_res", 67'(rsp_result), 67'(32'h8000_0000));
      chk("sub1_o", 67'(rsp_o), 67'(1));
      tick();

      // backpressure
      rsp_ready = 1'b0;
      send(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
      send(ALU_OR, 32'h1, 32'h2);
      send(ALU_XOR, 32'hFF, 32'h0F);
      chk("full_block", 67'(req_ready), 67'(0));
      chk("and_res", 67'(rsp_result), 67'(32'hF000));
      req_valid = 1'b1; req_ctrl = ALU_ADD; req_a = 32'd1; req_b = 32'd1;
      tick();
      tick();
      chk("stall_ready", 67'(req_ready), 67'(0));
      chk("stall_res", 67'(rsp_result), 67'(32'hF000));
      rsp_ready = 1'b1;
      send(ALU_ADD, 32'd1, 32'd1);
      chk("xor_res", 67'(rsp_result), 67'(32'hF0));
      tick();
      chk("add2_res", 67'(rsp_result), 67'(2));
      tick();
      tick();

      // full with push and pop in the same cycle, then streaming
      rsp_ready = 1'b0;
      send(ALU_ADD, 32'd10, 32'd20);
      send(ALU_SUB, 32'd5, 32'd3);
      send(ALU_SLL, 32'd1, 32'd4);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_ctrl = ALU_OR; req_a = 32'd8; req_b = 32'd1;
      chk("full_rej", 67'(req_ready), 67'(0));
      tick();
      chk("full_pop", 67'(rsp_result), 67'(2));
      send(ALU_OR, 32'd8, 32'd1);
      for (int i = 0; i < 11; i++) begin
         send(3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 40)));
      end
      repeat (4) tick();

      // reset mid-operation
      rsp_ready = 1'b0;
      send(ALU_XOR, 32'd3, 32'd5);
      send(ALU_ADD, 32'd3, 32'd5);
      send(ALU_SUB, 32'd3, 32'd5);
      chk("pre_rst_busy", 67'(busy), 67'(1));
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_stale", 67'(rsp_valid), 67'(0));
      end

      // shift and set-less-than
      send(ALU_SLL, 32'd1, 32'd31);
      send(ALU_SLT, 32'd3, 32'd2);
      chk("sll_res", 67'(rsp_result), 67'(32'h8000_0000));
      tick();
      chk("slt_res", 67'(rsp_result), 67'(0));
      tick();

      // random traffic with valid held until accepted
      for (int i = 0; i < 400; i++) begin
         acc = req_valid && req_ready;
         if (acc || !req_valid) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_ctrl  = 3'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) tick();
      chk("final_idle", 67'(busy), 67'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
